sseg_scan_decoder: RTL and testbench
====================================

SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples required before a digit is latched (legal range 2..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 2**20: cycles without any latch before the stale flag asserts (legal range 16..2**24).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 an_in  input  4  anode select from a scanned display, active-low, one-hot-low when valid.
REQ-006 sseg_in  input  8  segment bus, active-low; [7]=dp, [6:0]={g,f,e,d,c,b,a}.
REQ-007 digits  output  16  decoded hex value; digit i at [4i+3:4i], digit 0 = an_in[0].
REQ-008 dp  output  4  decimal point per digit, active-high.
REQ-009 seg_valid  output  4  per digit: last latched pattern was a legal hex glyph.
REQ-010 frame_valid  output  1  one-cycle pulse when all four digits have been latched since the last pulse or clear.
REQ-011 stale  output  1  high when no latch has occurred for TIMEOUT_CYCLES cycles.

Function
REQ-012 an_in and sseg_in shall pass through a two-flop synchronizer before any other use.
REQ-013 A synchronized sample is scannable only when exactly one an bit is low; all-high or multiple-low samples are non-scannable.
REQ-014 FSM states: IDLE, SETTLE, HELD.
REQ-015 IDLE: on a scannable sample, go to SETTLE with stable count = 1 and capture {an,sseg} as reference.
REQ-016 SETTLE: sample equal to reference increments count; on a different scannable sample, reload reference and set count = 1; on a non-scannable sample, go to IDLE.
REQ-017 When count reaches STABLE_CYCLES in SETTLE, latch the selected digit on that edge and go to HELD; total input-to-output latency = 2 + STABLE_CYCLES cycles.
REQ-018 HELD: no relatch while the sample equals the reference; a different scannable sample goes to SETTLE (count = 1); a non-scannable sample goes to IDLE.
REQ-019 Latch decode: the 16 standard active-low hex glyphs (0 = 0x40 on [6:0], 8 = 0x00, A = 0x08, b = 0x03, C = 0x46, d = 0x21, E = 0x06, F = 0x0E) map to 0..F with seg_valid[i] = 1.
REQ-020 Any other [6:0] pattern shall latch digit value 0 and seg_valid[i] = 0.
REQ-021 dp[i] shall latch the inverse of sseg[7] on every latch, independent of glyph legality.
REQ-022 Each latch sets seen[i]; on the edge where seen becomes 4'b1111, frame_valid pulses for one cycle and seen clears on the same edge.
REQ-023 Relatching an already-seen digit shall update its outputs and shall not pulse frame_valid.
REQ-024 Timeout counter clears on every latch, otherwise increments; saturates at TIMEOUT_CYCLES.
REQ-025 On reaching TIMEOUT_CYCLES, stale = 1 and seen clears; digits, dp and seg_valid hold their values.
REQ-026 The next latch clears stale on the same edge; if that latch completes a frame, both events occur.

Reset
REQ-027 On reset: digits = 0, dp = 0, seg_valid = 0, frame_valid = 0, stale = 0, seen = 0, counters = 0, synchronizers = all-ones, FSM = IDLE.
REQ-028 Reset asserted mid-settle or mid-frame shall discard the partial capture; no frame_valid pulse is generated by reset.

Structure
REQ-029 Package sseg_pkg holds the FSM state enum, the glyph constants and a pure decode function (7-bit pattern to {valid, nibble}).
REQ-030 The two-flop synchronizer is the only sub-module: sseg_sync, parameterized width, instanced once at width 12.

Verification
REQ-031 Drive an = 1110, sseg = 0xC0 for 10 cycles -> at cycle 6, digits[3:0] = 0, seg_valid[0] = 1, dp[0] = 0.
REQ-032 Scan digits 0..3 with 0xF9, 0xA4, 0xB0, 0x99, 8 cycles each -> digits = 0x4321, one frame_valid pulse, seg_valid = 1111.
REQ-033 an = 1100 for 20 cycles, then an = 1111 for 20 cycles -> no latch and no frame_valid.
REQ-034 Hold digit 2 at 0x9C (square glyph) -> digits[11:8] = 0, seg_valid[2] = 0, dp[2] = 0.
REQ-035 Toggle sseg every 3 cycles with STABLE_CYCLES = 4 -> no latch; then hold it stable -> latch 6 cycles after the last change.
REQ-036 TIMEOUT_CYCLES = 16 with no input activity -> stale = 1 at cycle 16; a subsequent latch clears it; assert reset mid-frame -> all outputs zero and seen cleared.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types and helpers for the scanned seven-segment decoder:
// scan FSM states, active-low hex glyph constants and pure decode helpers.
package sseg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } state_t;

   // Active-low segment patterns on {g,f,e,d,c,b,a} for hex digits 0..F.
   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h03;
   localparam logic [6:0] GLYPH_C = 7'h46;
   localparam logic [6:0] GLYPH_D = 7'h21;
   localparam logic [6:0] GLYPH_E = 7'h06;
   localparam logic [6:0] GLYPH_F = 7'h0E;

   // Map a 7-bit segment pattern to {valid, nibble}; unknown shapes give 0 and invalid.
   function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
      logic [4:0] res;
      case (pat)
         GLYPH_0: res = {1'b1, 4'h0};
         GLYPH_1: res = {1'b1, 4'h1};
         GLYPH_2: res = {1'b1, 4'h2};
         GLYPH_3: res = {1'b1, 4'h3};
         GLYPH_4: res = {1'b1, 4'h4};
         GLYPH_5: res = {1'b1, 4'h5};
         GLYPH_6: res = {1'b1, 4'h6};
         GLYPH_7: res = {1'b1, 4'h7};
         GLYPH_8: res = {1'b1, 4'h8};
         GLYPH_9: res = {1'b1, 4'h9};
         GLYPH_A: res = {1'b1, 4'hA};
         GLYPH_B: res = {1'b1, 4'hB};
         GLYPH_C: res = {1'b1, 4'hC};
         GLYPH_D: res = {1'b1, 4'hD};
         GLYPH_E: res = {1'b1, 4'hE};
         GLYPH_F: res = {1'b1, 4'hF};
         default: res = {1'b0, 4'h0};
      endcase
      return res;
   endfunction

   // True when exactly one active-low anode line is asserted.
   function automatic logic one_low(input logic [3:0] an);
      logic res;
      case (an)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
         default:                            res = 1'b0;
      endcase
      return res;
   endfunction

   // Digit position selected by a one-hot-low anode word.
   function automatic logic [1:0] an_index(input logic [3:0] an);
      logic [1:0] res;
      case (an)
         4'b1110: res = 2'd0;
         4'b1101: res = 2'd1;
         4'b1011: res = 2'd2;
         4'b0111: res = 2'd3;
         default: res = 2'd0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/sseg_sync.sv
// Two-flop synchronizer; resets to all-ones so an idle (all-high) display is seen.
module sseg_sync #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_r;

   // Two-stage capture of the asynchronous display bus.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_r <= {WIDTH{1'b1}};
         q      <= {WIDTH{1'b1}};
      end else begin
         meta_r <= d;
         q      <= meta_r;
      end
   end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Recovers the four hex digits shown on a multiplexed seven-segment display
// by debouncing each scanned {anode, segment} sample and decoding stable ones.
module sseg_scan_decoder
   import sseg_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 2**20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  an_in,
   input  logic [7:0]  sseg_in,
   output logic [15:0] digits,
   output logic [3:0]  dp,
   output logic [3:0]  seg_valid,
   output logic        frame_valid,
   output logic        stale
);

   localparam int               TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_MAX     = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [7:0]       STABLE_LAST = 8'(STABLE_CYCLES);

   logic [11:0]      sync_in_s;
   logic [11:0]      sync_out_s;
   logic [3:0]       an_s;
   logic [7:0]       sseg_s;
   logic             scan_s;
   logic             same_s;
   logic [1:0]       idx_s;
   logic [4:0]       dec_s;

   state_t           state_r;
   state_t           state_next_s;
   logic [11:0]      ref_r;
   logic [11:0]      ref_next_s;
   logic [7:0]       count_r;
   logic [7:0]       count_next_s;
   logic             latch_s;

   logic [3:0]       seen_r;
   logic [3:0]       seen_acc_s;
   logic [3:0]       seen_next_s;
   logic             frame_done_s;
   logic [TMO_W-1:0] tmo_r;
   logic [TMO_W-1:0] tmo_next_s;

   assign sync_in_s = {an_in, sseg_in};

   sseg_sync #(.WIDTH(12)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sync_in_s),
      .q     (sync_out_s)
   );

   assign an_s   = sync_out_s[11:8];
   assign sseg_s = sync_out_s[7:0];
   assign scan_s = one_low(an_s);
   assign same_s = (sync_out_s == ref_r);
   assign idx_s  = an_index(an_s);
   assign dec_s  = decode_glyph(sseg_s[6:0]);

   // Scan FSM state, reference sample and stability count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         ref_r   <= 12'hFFF;
         count_r <= 8'd0;
      end else begin
         state_r <= state_next_s;
         ref_r   <= ref_next_s;
         count_r <= count_next_s;
      end
   end

   // Next-state logic: count identical scannable samples, latch once on reaching the threshold.
   always_comb begin
      state_next_s = state_r;
      ref_next_s   = ref_r;
      count_next_s = count_r;
      latch_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (scan_s) begin
               state_next_s = ST_SETTLE;
               ref_next_s   = sync_out_s;
               count_next_s = 8'd1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (!scan_s) begin
               state_next_s = ST_IDLE;
               count_next_s = 8'd0;
            end else if (same_s) begin
               if ((count_r + 8'd1) == STABLE_LAST) begin
                  latch_s      = 1'b1;
                  state_next_s = ST_HELD;
                  count_next_s = STABLE_LAST;
               end else begin
                  count_next_s = count_r + 8'd1;
               end
            end else begin
               ref_next_s   = sync_out_s;
               count_next_s = 8'd1;
            end
         end
         ST_HELD: begin
            if (!scan_s) begin
               state_next_s = ST_IDLE;
               count_next_s = 8'd0;
            end else if (same_s) begin
               state_next_s = ST_HELD;
            end else begin
               state_next_s = ST_SETTLE;
               ref_next_s   = sync_out_s;
               count_next_s = 8'd1;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            count_next_s = 8'd0;
         end
      endcase
   end

   // Frame tracking and inactivity timeout; a latch always restarts the timeout.
   always_comb begin
      seen_acc_s   = seen_r;
      frame_done_s = 1'b0;
      seen_next_s  = seen_r;
      tmo_next_s   = tmo_r;
      if (latch_s) begin
         seen_acc_s = seen_r | (4'b0001 << idx_s);
         tmo_next_s = {TMO_W{1'b0}};
      end else if (tmo_r == TMO_MAX) begin
         tmo_next_s = tmo_r;
      end else begin
         tmo_next_s = tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
      end
      frame_done_s = latch_s && (seen_acc_s == 4'b1111);
      if (frame_done_s) begin
         seen_next_s = 4'b0000;
      end else if (tmo_next_s == TMO_MAX) begin
         seen_next_s = 4'b0000;
      end else begin
         seen_next_s = seen_acc_s;
      end
   end

   // Registered digit outputs, frame pulse and stale flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digits      <= 16'h0000;
         dp          <= 4'b0000;
         seg_valid   <= 4'b0000;
         frame_valid <= 1'b0;
         stale       <= 1'b0;
         seen_r      <= 4'b0000;
         tmo_r       <= {TMO_W{1'b0}};
      end else begin
         if (latch_s) begin
            digits[{idx_s, 2'b00} +: 4] <= dec_s[3:0];
            seg_valid[idx_s]            <= dec_s[4];
            dp[idx_s]                   <= ~sseg_s[7];
         end
         frame_valid <= frame_done_s;
         stale       <= (tmo_next_s == TMO_MAX);
         seen_r      <= seen_next_s;
         tmo_r       <= tmo_next_s;
      end
   end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Self-checking bench for sseg_scan_decoder: a run-length reference model
// compared every cycle, plus hand-computed checks at key points.
module tb_sseg_scan_decoder;

   localparam int STABLE  = 4;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  an_in = 4'hF;
   logic [7:0]  sseg_in = 8'hFF;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic [3:0]  seg_valid;
   logic        frame_valid;
   logic        stale;

   int n_cmp = 0;
   int n_bad = 0;
   int fv_count = 0;

   sseg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .an_in       (an_in),
      .sseg_in     (sseg_in),
      .digits      (digits),
      .dp          (dp),
      .seg_valid   (seg_valid),
      .frame_valid (frame_valid),
      .stale       (stale)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [6:0]  glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [11:0] m_hist [3];
   logic [11:0] m_prev;
   bit          m_prev_scan;
   int          m_run;
   int          m_nib [4];
   bit          m_sv [4];
   bit          m_dp [4];
   bit          m_seen [4];
   bit          m_fv;
   bit          m_stale;
   int          m_tmo;

   task automatic model_clear();
      for (int i = 0; i < 3; i++) m_hist[i] = 12'hFFF;
      m_prev = 12'hFFF; m_prev_scan = 1'b0; m_run = 0;
      for (int i = 0; i < 4; i++) begin
         m_nib[i] = 0; m_sv[i] = 1'b0; m_dp[i] = 1'b0; m_seen[i] = 1'b0;
      end
      m_fv = 1'b0; m_stale = 1'b0; m_tmo = 0;
   endtask

   // Sample seen by the decoder is the raw input from two clocks earlier.
   task automatic model_step();
      logic [11:0] s;
      int zeros, idx;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = {an_in, sseg_in};
      s = m_hist[2];
      zeros = 0; idx = 0;
      for (int i = 0; i < 4; i++) if (!s[8+i]) begin zeros++; idx = i; end
      if (zeros != 1) m_run = 0;
      else if (m_prev_scan && s == m_prev) m_run = (m_run < 255) ? m_run + 1 : m_run;
      else m_run = 1;
      m_prev = s;
      m_prev_scan = (zeros == 1);
      m_fv = 1'b0;
      if (m_run == STABLE) begin
         m_nib[idx] = 0; m_sv[idx] = 1'b0;
         for (int g = 0; g < 16; g++)
            if (s[6:0] == glyph_tab[g]) begin m_nib[idx] = g; m_sv[idx] = 1'b1; end
         m_dp[idx] = !s[7];
         m_seen[idx] = 1'b1;
         m_tmo = 0; m_stale = 1'b0;
         if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
            m_fv = 1'b1;
            for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
         end
      end else begin
         if (m_tmo < TIMEOUT) m_tmo++;
         if (m_tmo == TIMEOUT) begin
            m_stale = 1'b1;
            for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
         end
      end
   endtask

   function automatic logic [25:0] model_vec();
      logic [15:0] d; logic [3:0] p, v;
      d = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         d = d | (16'(m_nib[i]) << (4 * i));
         p[i] = m_dp[i];
         v[i] = m_sv[i];
      end
      return {d, p, v, m_fv, m_stale};
   endfunction

   initial begin
      model_clear();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) model_clear();
         else model_step();
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic [25:0] act, exp;
      act = {digits, dp, seg_valid, frame_valid, stale};
      exp = model_vec();
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL model_cmp t=%0t: dut dig=%h dp=%b sv=%b fv=%b st=%b, model dig=%h dp=%b sv=%b fv=%b st=%b",
                  $time, act[25:10], act[9:6], act[5:2], act[1], act[0],
                  exp[25:10], exp[9:6], exp[5:2], exp[1], exp[0]);
      end
      if (frame_valid === 1'b1) fv_count++;
   end

   // ---------------- directed stimulus ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] a, input logic [7:0] s);
      an_in = a;
      sseg_in = s;
   endtask

   int fv_base;

   initial begin
      // Reset state
      cyc(3);
      check("reset_outputs", {6'd0, digits, dp, seg_valid, frame_valid, stale}, 32'h0);
      reset = 1'b0;

      // Timeout with no activity: stale on the 16th clock
      cyc(15);
      check("stale_before_timeout", {31'd0, stale}, 32'd0);
      cyc(1);
      check("stale_at_timeout", {31'd0, stale}, 32'd1);

      // Digit 0 shows '0' with dp off; latch on the 6th clock
      drive(4'b1110, 8'hC0);
      cyc(5);
      check("d0_not_yet_valid", {28'd0, seg_valid}, 32'h0);
      check("d0_stale_still_set", {31'd0, stale}, 32'd1);
      cyc(1);
      check("d0_digit", {28'd0, digits[3:0]}, 32'h0);
      check("d0_valid", {28'd0, seg_valid}, 32'h1);
      check("d0_dp", {31'd0, dp[0]}, 32'd0);
      check("d0_stale_cleared", {31'd0, stale}, 32'd0);
      cyc(4);

      // Full scan 1,2,3,4
      fv_base = fv_count;
      drive(4'b1110, 8'hF9); cyc(8);
      drive(4'b1101, 8'hA4); cyc(8);
      drive(4'b1011, 8'hB0); cyc(8);
      drive(4'b0111, 8'h99); cyc(8);
      check("scan_digits", {16'd0, digits}, 32'h4321);
      check("scan_valid", {28'd0, seg_valid}, 32'hF);
      check("scan_frame_pulses", fv_count - fv_base, 32'd1);

      // Multiple-low then all-high anodes: nothing latches
      fv_base = fv_count;
      drive(4'b1100, 8'hC0); cyc(20);
      drive(4'b1111, 8'hC0); cyc(20);
      check("nonscan_digits", {16'd0, digits}, 32'h4321);
      check("nonscan_pulses", fv_count - fv_base, 32'd0);
      check("nonscan_stale", {31'd0, stale}, 32'd1);

      // Illegal glyph on digit 2
      drive(4'b1011, 8'h9C); cyc(10);
      check("bad_glyph_digit", {28'd0, digits[11:8]}, 32'h0);
      check("bad_glyph_valid", {28'd0, seg_valid}, 32'hB);
      check("bad_glyph_dp", {31'd0, dp[2]}, 32'd0);
      check("bad_glyph_stale", {31'd0, stale}, 32'd0);

      // Digit 1 shows '4' with decimal point lit
      drive(4'b1101, 8'h19); cyc(10);
      check("dp_on_digits", {16'd0, digits}, 32'h4041);
      check("dp_on_dp", {28'd0, dp}, 32'h2);

      // Toggle digit 3 every 3 cycles: no latch; then hold
      for (int k = 0; k < 6; k++) begin
         drive(4'b0111, (k % 2 == 0) ? 8'h92 : 8'h82);
         cyc(3);
      end
      check("toggle_no_latch", {28'd0, digits[15:12]}, 32'h4);
      drive(4'b0111, 8'h92);
      cyc(5);
      check("hold_before_latch", {28'd0, digits[15:12]}, 32'h4);
      cyc(1);
      check("hold_latched", {28'd0, digits[15:12]}, 32'h5);
      cyc(2);

      // Partial frame then reset mid-settle
      drive(4'b1110, 8'hF9); cyc(8);
      drive(4'b1011, 8'hB0); cyc(8);
      drive(4'b1101, 8'hA4); cyc(3);
      #2 reset = 1'b1;
      #1;
      check("midframe_reset_outputs", {6'd0, digits, dp, seg_valid, frame_valid, stale}, 32'h0);
      cyc(2);
      reset = 1'b0;
      fv_base = fv_count;
      cyc(8);
      check("after_reset_no_frame", fv_count - fv_base, 32'd0);
      drive(4'b1110, 8'hF9); cyc(8);
      drive(4'b1011, 8'hB0); cyc(8);
      drive(4'b0111, 8'h99); cyc(8);
      check("after_reset_one_frame", fv_count - fv_base, 32'd1);
      check("after_reset_digits", {16'd0, digits}, 32'h4321);

      drive(4'b1111, 8'hFF); cyc(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
